// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: branch funct3 encodings and the PC increment.
package rv_pipe_pkg;

  // Conditional-branch funct3 encodings; 010 and 011 are unused.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  // Distance from an instruction to its sequential successor (link value).
  localparam int unsigned PC_INC = 4;

endpackage : rv_pipe_pkg

// File: rtl/branch_cmp.sv
// Combinational branch resolution: decides whether a conditional branch is taken.
module branch_cmp
  import rv_pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         branch,
  input  logic [2:0]   funct3,
  input  logic         zero_flag,
  input  logic [N-1:0] alu_a,
  input  logic [N-1:0] alu_b,
  output logic         taken
);

  logic lt_signed;
  logic lt_unsigned;
  logic cond;

  // Compare the operands directly; the ALU carry/overflow flags are never consulted.
  assign lt_signed   = $signed(alu_a) < $signed(alu_b);
  assign lt_unsigned = alu_a < alu_b;

  // Select the branch condition from funct3; reserved encodings resolve not-taken.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves cond unassigned (no latch).
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero_flag;
      F3_BNE:  cond = !zero_flag;
      F3_BLT:  cond = lt_signed;
      F3_BGE:  cond = !lt_signed;
      F3_BLTU: cond = lt_unsigned;
      F3_BGEU: cond = !lt_unsigned;
      default: cond = 1'b0;
    endcase
    taken = branch & cond;
  end

endmodule : branch_cmp

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures EX results, resolves control flow and
// produces a one-shot redirect for taken branches, jal and jalr.
module ex_mem_stage
  import rv_pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alu_a,
  input  logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_result,
  input  logic         zero_flag,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] rs2_data,
  input  logic [4:0]   rd_addr,
  input  logic [2:0]   funct3,
  input  logic         in_valid,
  input  logic         branch,
  input  logic         jal,
  input  logic         jalr,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         reg_write,
  input  logic         mem_to_reg,
  input  logic         stall,
  input  logic         flush,
  output logic         m_valid,
  output logic         m_mem_read,
  output logic         m_mem_write,
  output logic         m_reg_write,
  output logic         m_mem_to_reg,
  output logic [N-1:0] m_result,
  output logic [N-1:0] m_store_data,
  output logic [4:0]   m_rd,
  output logic         redirect,
  output logic [N-1:0] redirect_pc,
  output logic         misaligned
);

  logic         taken;
  logic         do_redirect;
  logic [N-1:0] target;
  logic [N-1:0] link_pc;

  branch_cmp #(.N(N)) u_branch_cmp (
    .branch    (branch),
    .funct3    (funct3),
    .zero_flag (zero_flag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .taken     (taken)
  );

  // Control-flow target and link value; additions wrap modulo 2^N.
  assign target      = jalr ? {alu_result[N-1:1], 1'b0} : pc + imm;
  assign link_pc     = pc + N'(PC_INC);
  assign do_redirect = taken | jal | jalr;

  // Pipeline register with priority rst > flush > stall > accept/bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data fields are reset too (not only the valid/controls) so the stage comes up in a fully defined state.
      m_valid      <= 1'b0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_reg_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      redirect     <= 1'b0;
      misaligned   <= 1'b0;
      m_result     <= '0;
      m_store_data <= '0;
      redirect_pc  <= '0;
      m_rd         <= '0;
    end else if (flush) begin
      // Squash: controls cleared, data fields left as they are.
      m_valid      <= 1'b0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_reg_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      redirect     <= 1'b0;
      misaligned   <= 1'b0;
    end else if (stall) begin
      // Hold everything, but drop redirect so a stalled branch redirects once.
      redirect     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      m_valid      <= in_valid;
      m_mem_read   <= in_valid & mem_read  & !branch;
      m_mem_write  <= in_valid & mem_write & !branch;
      m_reg_write  <= in_valid & reg_write & !branch;
      m_mem_to_reg <= in_valid & mem_to_reg;
      redirect     <= in_valid & do_redirect;
      misaligned   <= in_valid & do_redirect & target[1];
      m_result     <= (jal | jalr) ? link_pc : alu_result;
      m_store_data <= rs2_data;
      redirect_pc  <= target;
      m_rd         <= rd_addr;
    end
  end

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random
// stimulus compared against a behavioural model of the stage.
module tb_ex_mem_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] alu_a, alu_b, alu_result, pc, imm, rs2_data;
  logic         zero_flag;
  logic [4:0]   rd_addr;
  logic [2:0]   funct3;
  logic         in_valid, branch, jal, jalr, mem_read, mem_write, reg_write, mem_to_reg;
  logic         stall, flush;
  logic         m_valid, m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg;
  logic [N-1:0] m_result, m_store_data, redirect_pc;
  logic [4:0]   m_rd;
  logic         redirect, misaligned;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .zero_flag    (zero_flag),
    .pc           (pc),
    .imm          (imm),
    .rs2_data     (rs2_data),
    .rd_addr      (rd_addr),
    .funct3       (funct3),
    .in_valid     (in_valid),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .stall        (stall),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_mem_read   (m_mem_read),
    .m_mem_write  (m_mem_write),
    .m_reg_write  (m_reg_write),
    .m_mem_to_reg (m_mem_to_reg),
    .m_result     (m_result),
    .m_store_data (m_store_data),
    .m_rd         (m_rd),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misaligned   (misaligned)
  );

  // Expected stage contents; data_known marks when the data fields are defined.
  typedef struct {
    bit          valid, mr, mw, rw, m2r, redir, mis, data_known;
    bit [N-1:0]  result, sdata, rpc;
    bit [4:0]    rd;
  } exp_t;

  exp_t exp_s;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Branch outcome straight from the ISA definition of each condition.
  function automatic bit branch_taken(bit [2:0] f3, bit zf, bit [N-1:0] a, bit [N-1:0] b);
    int signed  sa = int'(a);
    int signed  sb = int'(b);
    longint     ua = longint'(a);
    longint     ub = longint'(b);
    case (f3)
      3'd0:    return zf;
      3'd1:    return !zf;
      3'd4:    return sa <  sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua <  ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // State the stage should hold after the next edge, given current inputs.
  function automatic exp_t model_next(exp_t cur);
    exp_t   n = cur;
    bit     go;
    longint tgt;
    if (rst) begin
      n = '{default: 0};
      n.data_known = 1'b1;
    end else if (flush) begin
      n.valid = 0; n.mr = 0; n.mw = 0; n.rw = 0; n.m2r = 0; n.redir = 0; n.mis = 0;
      n.data_known = 0;
    end else if (stall) begin
      n.redir = 0;
    end else if (!in_valid) begin
      n = '{default: 0};
    end else begin
      go = (branch && branch_taken(funct3, zero_flag, alu_a, alu_b)) || jal || jalr;
      if (jalr) tgt = (longint'(alu_result) / 2) * 2;
      else      tgt = (longint'(pc) + longint'(imm)) % (64'd1 << N);
      n.valid      = 1;
      n.mr         = mem_read  && !branch;
      n.mw         = mem_write && !branch;
      n.rw         = reg_write && !branch;
      n.m2r        = mem_to_reg;
      n.redir      = go;
      n.rpc        = N'(tgt);
      n.mis        = go && ((tgt % 4) >= 2);
      n.result     = (jal || jalr) ? N'((longint'(pc) + 4) % (64'd1 << N)) : alu_result;
      n.sdata      = rs2_data;
      n.rd         = rd_addr;
      n.data_known = 1;
    end
    return n;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ":valid"}, N'(m_valid),      N'(exp_s.valid));
    check({tag, ":mr"},    N'(m_mem_read),   N'(exp_s.mr));
    check({tag, ":mw"},    N'(m_mem_write),  N'(exp_s.mw));
    check({tag, ":rw"},    N'(m_reg_write),  N'(exp_s.rw));
    check({tag, ":m2r"},   N'(m_mem_to_reg), N'(exp_s.m2r));
    check({tag, ":redir"}, N'(redirect),     N'(exp_s.redir));
    check({tag, ":mis"},   N'(misaligned),   N'(exp_s.mis));
    if (exp_s.data_known) begin
      check({tag, ":result"}, m_result,     exp_s.result);
      check({tag, ":sdata"},  m_store_data, exp_s.sdata);
      check({tag, ":rd"},     N'(m_rd),     N'(exp_s.rd));
      if (exp_s.redir || !exp_s.valid) check({tag, ":rpc"}, redirect_pc, exp_s.rpc);
    end
  endtask

  // Advance one clock with the current inputs and compare against the model.
  task automatic step(input string tag);
    exp_t nxt = model_next(exp_s);
    @(posedge clk);
    exp_s = nxt;
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; in_valid = 0;
    branch = 0; jal = 0; jalr = 0;
    mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    alu_a = '0; alu_b = '0; alu_result = '0; zero_flag = 0;
    pc = '0; imm = '0; rs2_data = '0; rd_addr = '0; funct3 = '0;
  endtask

  function automatic logic [N-1:0] pick_operand();
    logic [N-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 9) < 3) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  task automatic random_inputs();
    int kind = $urandom_range(0, 9);
    idle_inputs();
    rst        = ($urandom_range(0, 99) < 3);
    flush      = ($urandom_range(0, 99) < 8);
    stall      = ($urandom_range(0, 99) < 20);
    in_valid   = ($urandom_range(0, 99) < 85);
    alu_a      = pick_operand();
    alu_b      = ($urandom_range(0, 3) == 0) ? alu_a : pick_operand();
    zero_flag  = (alu_a == alu_b);
    alu_result = $urandom();
    pc         = $urandom();
    imm        = $urandom();
    rs2_data   = $urandom();
    rd_addr    = 5'($urandom());
    funct3     = 3'($urandom());
    mem_read   = 1'($urandom());
    mem_write  = 1'($urandom());
    reg_write  = 1'($urandom());
    mem_to_reg = 1'($urandom());
    if (kind < 4)       branch = 1;
    else if (kind == 4) jal    = 1;
    else if (kind == 5) jalr   = 1;
  endtask

  initial begin
    exp_s = '{default: 0};
    idle_inputs();

    // Reset state.
    rst = 1;
    step("reset0");
    step("reset1");
    check("reset_rpc", redirect_pc, 32'h0);
    rst = 0;

    // BLTU 5 < 0 unsigned is false: no redirect.
    in_valid = 1; branch = 1; funct3 = 3'b110; alu_a = 32'd5; alu_b = 32'd0;
    pc = 32'h100; imm = 32'h20; reg_write = 1;
    step("bltu_nt");
    check("bltu_nt_redirect", N'(redirect), 32'h0);
    check("bltu_rw_forced", N'(m_reg_write), 32'h0);

    // BLT -1 < 1 signed: taken to pc+imm.
    funct3 = 3'b100; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
    step("blt_t");
    check("blt_redirect", N'(redirect), 32'h1);
    check("blt_rpc", redirect_pc, 32'h120);

    // JALR to an odd, half-word-aligned target.
    idle_inputs(); in_valid = 1; jalr = 1; alu_result = 32'h203; pc = 32'h40; reg_write = 1;
    step("jalr");
    check("jalr_rpc", redirect_pc, 32'h202);
    check("jalr_mis", N'(misaligned), 32'h1);
    check("jalr_link", m_result, 32'h44);

    // Taken BEQ, then three stalled cycles: single-cycle redirect, data held.
    idle_inputs(); in_valid = 1; branch = 1; funct3 = 3'b000; zero_flag = 1;
    pc = 32'h1000; imm = 32'h10; alu_result = 32'hABCD;
    step("beq");
    check("beq_redirect", N'(redirect), 32'h1);
    stall = 1; pc = 32'h5555; alu_result = 32'h7777;
    for (int i = 0; i < 3; i++) begin
      step("beq_stall");
      check("stall_redirect_low", N'(redirect), 32'h0);
      check("stall_hold_valid", N'(m_valid), 32'h1);
      check("stall_hold_result", m_result, 32'hABCD);
    end

    // Flush together with stall on a valid add squashes it.
    idle_inputs(); in_valid = 1; reg_write = 1; alu_result = 32'h3; rd_addr = 5'd7;
    step("add");
    flush = 1; stall = 1;
    step("flush_stall");
    check("flush_valid", N'(m_valid), 32'h0);
    check("flush_rw", N'(m_reg_write), 32'h0);

    // Reset coincident with a taken JAL, then the same JAL wrapping around.
    idle_inputs(); in_valid = 1; jal = 1; pc = 32'hFFFF_FFFC; imm = 32'h8; reg_write = 1; rst = 1;
    step("jal_rst");
    check("jal_rst_redirect", N'(redirect), 32'h0);
    check("jal_rst_rpc", redirect_pc, 32'h0);
    check("jal_rst_result", m_result, 32'h0);
    rst = 0;
    step("jal_wrap");
    check("jal_wrap_rpc", redirect_pc, 32'h4);
    check("jal_wrap_link", m_result, 32'h0);

    // Reset asserted mid-stall after a taken branch.
    idle_inputs(); in_valid = 1; jal = 1; pc = 32'h80; imm = 32'h40;
    step("jal_pre");
    stall = 1; rst = 1;
    step("rst_stall");
    check("rst_stall_valid", N'(m_valid), 32'h0);
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ex_mem_stage
